fpu_uart_tx: RTL and testbench

Byte-serial UART transmitter for the FPU test system, the transmit counterpart of the `UART_RX` receive path. It accepts bytes from the CPU-side I/O logic, for example FPU result dumps, over a write-strobe interface. Bytes are buffered in a small FIFO and shifted out on a single line as 8N1 frames, LSB first, at a fixed divisor-derived baud rate. Its line output is routed to `UART_TX` or to a `JB` pin at the system top.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/fpu_uart_tx.sv | 148 ++++++++++++++
 tb/tb_fpu_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FPU test-system UART transmitter.
package uart_pkg;

    // Transmit FSM states, one per part of an 8N1 frame plus the idle line.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Frame shape: 8 data bits, one start and one stop bit.
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // 50 MHz system clock divided down to 115200 baud.
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the UART shifter.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Status is derived only from the registered occupancy count.
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array: written on an accepted push.
    // NOTE: the data array has no reset; pointers and level define validity,
    // so resetting it would only cost flops and routing.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/fpu_uart_tx.sv
// 8N1 UART transmitter with a small write-side FIFO.
// Bytes are sent LSB first; back-to-back frames have no idle gap.
module fpu_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        SI_ClkIn,
    input  logic                        SI_Reset_N,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_en,
    input  logic                        clr_ovf,
    output logic                        full,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        ovf,
    output logic                        tx
);

    localparam int               CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e                 r_state;
    logic [CW-1:0]               r_baud;
    logic [2:0]                  r_bit;
    logic [7:0]                  r_shift;
    logic                        r_tx;
    logic                        r_ovf;

    logic [7:0]                  w_fifo_data;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_level;
    logic                        w_baud_done;
    logic                        w_pop;

    assign w_baud_done = (r_baud == BAUD_LAST);

    // The FIFO is popped only when the FSM moves into START.
    assign w_pop = ~w_fifo_empty &
                   ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_done));

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (SI_ClkIn),
        .i_rst_n (SI_Reset_N),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    assign full  = w_fifo_full;
    assign level = w_level;
    assign busy  = (r_state != ST_IDLE) | (w_level != '0);
    assign ovf   = r_ovf;
    assign tx    = r_tx;

    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            r_ovf <= 1'b0;
        end else if (wr_en && w_fifo_full) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Frame sequencer: state, baud counter, bit index, shifter and line driver.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_shift <= w_fifo_data;
                        r_tx    <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_baud_done) begin
                        r_state <= ST_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_shift <= w_fifo_data;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_uart_tx.sv
// Self-checking bench for fpu_uart_tx: a queue/countdown reference model
// predicts status and line level every cycle, and a line decoder compares
// received bytes against a scoreboard of bytes the model says were popped.
module tb_fpu_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          full;
    logic          busy;
    logic [LW-1:0] level;
    logic          ovf;
    logic          tx;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    int         m_rem = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;

    fpu_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .clr_ovf    (clr_ovf),
        .full       (full),
        .busy       (busy),
        .level      (level),
        .ovf        (ovf),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using pre-edge inputs and occupancy.
    task automatic model_edge();
        bit full_pre;
        bit do_pop;
        full_pre = (model_q.size() == DEPTH);
        do_pop   = (model_q.size() != 0) && (m_rem <= 1);
        if (wr_en && full_pre) m_ovf = 1'b1;
        else if (clr_ovf)      m_ovf = 1'b0;
        if (do_pop) begin
            m_cur = model_q.pop_front();
            exp_q.push_back(m_cur);
            m_rem = FRAME;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (wr_en && !full_pre) model_q.push_back(wr_data);
    endtask

    // Line level implied by the position within the current frame.
    function automatic logic model_tx();
        int b;
        if (m_rem == 0) return 1'b1;
        b = (FRAME - m_rem) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic check_outputs();
        logic [LW-1:0] exp_level;
        exp_level = LW'(model_q.size());
        check("tx", 32'(tx), 32'(model_tx()));
        check("level/full/busy/ovf", 32'({level, full, busy, ovf}),
              32'({exp_level, model_q.size() == DEPTH,
                   (m_rem != 0) || (model_q.size() != 0), m_ovf}));
    endtask

    // One clock with the given inputs, then compare at the falling edge.
    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        wr_en   = we;
        wr_data = d;
        clr_ovf = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check_outputs();
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_rem != 0 || model_q.size() != 0) && guard < 2000) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        repeat (2) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " tx"},    32'(tx),    32'd1);
        check({tag, " level"}, 32'(level), 32'd0);
        check({tag, " full"},  32'(full),  32'd0);
        check({tag, " busy"},  32'(busy),  32'd0);
        check({tag, " ovf"},   32'(ovf),   32'd0);
    endtask

    // Line decoder: samples each bit mid-period and scores the received byte.
    task automatic monitor();
        logic [FRAME-1:0] smp;
        logic [7:0]       got;
        logic [7:0]       exp;
        bit               aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                aborted = 1'b0;
                smp[0]  = tx;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[k] = tx;
                end
                if (!aborted) begin
                    for (int b = 0; b < 8; b++) got[b] = smp[(b + 1) * CPB + CPB / 2];
                    check("frame expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("rx byte", 32'(got), 32'(exp));
                    end
                    check("start/stop", 32'({smp[CPB / 2], smp[9 * CPB + CPB / 2]}), 32'b01);
                end
            end
        end
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: bench did not finish within 200000 time units");
                $fatal(1, "timeout");
            end
        join_none

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        fork
            monitor();
        join_none

        // Single byte from idle.
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("single tx falls", 32'(tx), 32'd0);
        drain();

        // Back-to-back frames.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h0F, 1'b0);
        drain();

        // Overflow: six writes, sixth dropped; then a dropped write with clear.
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        check("ovf after drop", 32'(ovf), 32'd1);
        step(1'b1, 8'h07, 1'b1);
        check("ovf set beats clear", 32'(ovf), 32'd1);
        drain();
        step(1'b0, 8'h00, 1'b1);
        check("ovf cleared", 32'(ovf), 32'd0);

        // Push on the exact STOP->START pop cycle with two bytes queued.
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h96, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        for (int g = 0; g < 100 && m_rem != 1; g++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        check("push+pop level", 32'(level), 32'd2);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0, 8'($urandom),
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end
        drain();

        // Reset during DATA bit 3 with ovf set and a full FIFO.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(8'h10 * i), 1'b0);
        for (int g = 0; g < 100 && (FRAME - m_rem) / CPB != 4; g++) step(1'b0, 8'h00, 1'b0);
        check("pre-reset ovf", 32'(ovf), 32'd1);
        @(posedge clk);
        model_edge();
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        model_q.delete();
        exp_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs();
        step(1'b1, 8'hC3, 1'b0);
        drain();

        check("frames pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
